// File: rtl/gpu_cmd_pkg.sv
// -----------------------------------------------------------------------------
// gpu_cmd_pkg
//   Shared definitions for the GPU command-word stream: opcode constants,
//   header field widths, the packed header layout and the state encoding of
//   the stream initiator (cmd_stream_tx).
// -----------------------------------------------------------------------------
package gpu_cmd_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned OPCODE_W = 8;
  localparam int unsigned FLAGS_W  = 8;
  localparam int unsigned LEN_W    = 16;

  localparam logic [OPCODE_W-1:0] OP_CLEAR         = 8'h01;
  localparam logic [OPCODE_W-1:0] OP_DRAW_TRIANGLE = 8'h02;
  localparam logic [OPCODE_W-1:0] OP_SET_COLOR     = 8'h10;
  localparam logic [OPCODE_W-1:0] OP_SET_VIEWPORT  = 8'h11;

  // Header word as it appears on cmd_data: {opcode, flags, len}.
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FLAGS_W-1:0]  flags;
    logic [LEN_W-1:0]    len;
  } cmd_hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/cmd_payload_buf.sv
// -----------------------------------------------------------------------------
// cmd_payload_buf
//   MAX_PAYLOAD x 32-bit register file holding the argument words of the next
//   packet. One synchronous write port, one combinational read port.
//
// Ports:
//   clk      system clock
//   wr_en    write strobe (already gated by the caller while a packet is live)
//   wr_idx   write word index; indices >= MAX_PAYLOAD are dropped
//   wr_data  write word
//   rd_idx   read word index (word counter of the serialiser)
//   rd_data  combinational read data
// -----------------------------------------------------------------------------
module cmd_payload_buf
  import gpu_cmd_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 8,
  parameter int unsigned IDX_W       = $clog2(MAX_PAYLOAD)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [MAX_PAYLOAD];

  // NOTE: storage arrays carry no reset; software always stages arguments
  // before issuing, and a reset term would turn the array into wide flops
  // with reset muxes for no functional gain.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_idx) < MAX_PAYLOAD)) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // The serialiser only addresses words below the latched len, which is
  // already bounded by MAX_PAYLOAD, so rd_idx is always in range when used.
  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/cmd_stream_tx.sv
// -----------------------------------------------------------------------------
// cmd_stream_tx
//   Initiator of the GPU command-word stream. Software stages argument words
//   in a local buffer, then pulses issue; the block sends one header word
//   {opcode, flags, len} followed by len payload words, honouring cmd_ready.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   arg_wr_en/idx/data       payload buffer write port (ignored while busy)
//   issue, issue_opcode,
//   issue_flags, issue_len   single-cycle packet request
//   cmd_valid, cmd_data      stream word out (registered)
//   cmd_ready                consumer accepts the word on this edge
//   busy                     packet in flight
//   done                     one-cycle pulse after the final word moves
//   err_len                  one-cycle pulse: issue with len > MAX_PAYLOAD
//   err_wr                   sticky: arg write while busy; cleared on issue
//
// Optional build macro CMD_STREAM_TX_STATS_EN adds saturating counters
//   stat_pkts (done pulses), stat_words (transfers), stat_stall (stall cycles).
// -----------------------------------------------------------------------------
module cmd_stream_tx
  import gpu_cmd_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 8,
  parameter int unsigned IDX_W       = $clog2(MAX_PAYLOAD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arg_wr_en,
  input  logic [IDX_W-1:0]    arg_wr_idx,
  input  logic [WORD_W-1:0]   arg_wr_data,
  input  logic                issue,
  input  logic [OPCODE_W-1:0] issue_opcode,
  input  logic [FLAGS_W-1:0]  issue_flags,
  input  logic [LEN_W-1:0]    issue_len,
  output logic                cmd_valid,
  output logic [WORD_W-1:0]   cmd_data,
  input  logic                cmd_ready,
  output logic                busy,
  output logic                done,
  output logic                err_len,
  output logic                err_wr
`ifdef CMD_STREAM_TX_STATS_EN
  ,
  output logic [31:0]         stat_pkts,
  output logic [31:0]         stat_words,
  output logic [31:0]         stat_stall
`endif
);

  tx_state_e         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              valid_d;
  logic [WORD_W-1:0] data_d;
  logic              done_d, err_len_d, err_wr_d;
  logic [WORD_W-1:0] rd_data;
  cmd_hdr_t          hdr;
  logic              xfer;

  assign xfer = cmd_valid && cmd_ready;
  assign hdr  = '{opcode: issue_opcode, flags: issue_flags, len: issue_len};

  // Writes are blocked while busy, so a packet in flight always sends the
  // arguments that were staged when it was issued.
  cmd_payload_buf #(
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .IDX_W       (IDX_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (arg_wr_en && !busy),
    .wr_idx  (arg_wr_idx),
    .wr_data (arg_wr_data),
    .rd_idx  (cnt_q[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  // NOTE: every signal assigned here gets its default first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    valid_d   = cmd_valid;
    data_d    = cmd_data;
    done_d    = 1'b0;
    err_len_d = 1'b0;
    err_wr_d  = err_wr;

    if (arg_wr_en && busy) begin
      err_wr_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (issue) begin
          if (32'(issue_len) > MAX_PAYLOAD) begin
            err_len_d = 1'b1;
          end else begin
            data_d   = hdr;
            valid_d  = 1'b1;
            len_d    = issue_len;
            cnt_d    = '0;
            err_wr_d = 1'b0;
            state_d  = ST_HDR;
          end
        end
      end

      // cnt_q is 0 here, so rd_data is buf[0]; loading it on the header
      // transfer edge keeps the stream bubble-free.
      ST_HDR: begin
        if (xfer) begin
          if (len_q == '0) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            data_d  = rd_data;
            cnt_d   = LEN_W'(1);
            state_d = ST_PAY;
          end
        end
      end

      // cnt_q counts payload words already loaded onto cmd_data.
      ST_PAY: begin
        if (xfer) begin
          if (cnt_q == len_q) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            data_d = rd_data;
            cnt_d  = cnt_q + LEN_W'(1);
          end
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_len   <= 1'b0;
      err_wr    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      cmd_valid <= valid_d;
      cmd_data  <= data_d;
      busy      <= (state_d != ST_IDLE);
      done      <= done_d;
      err_len   <= err_len_d;
      err_wr    <= err_wr_d;
    end
  end

`ifdef CMD_STREAM_TX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkts  <= '0;
      stat_words <= '0;
      stat_stall <= '0;
    end else begin
      if (done && (stat_pkts != '1)) begin
        stat_pkts <= stat_pkts + 32'd1;
      end
      if (xfer && (stat_words != '1)) begin
        stat_words <= stat_words + 32'd1;
      end
      if (cmd_valid && !cmd_ready && (stat_stall != '1)) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cmd_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_cmd_stream_tx
//   Directed bench for cmd_stream_tx (MAX_PAYLOAD = 8). Inputs are driven and
//   outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_cmd_stream_tx;
  import gpu_cmd_pkg::*;

  localparam int unsigned MAXP = 8;
  localparam int unsigned IW   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        arg_wr_en;
  logic [IW-1:0] arg_wr_idx;
  logic [31:0] arg_wr_data;
  logic        issue;
  logic [7:0]  issue_opcode;
  logic [7:0]  issue_flags;
  logic [15:0] issue_len;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        busy;
  logic        done;
  logic        err_len;
  logic        err_wr;
`ifdef CMD_STREAM_TX_STATS_EN
  logic [31:0] stat_pkts;
  logic [31:0] stat_words;
  logic [31:0] stat_stall;
`endif

  cmd_stream_tx #(.MAX_PAYLOAD(MAXP), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .arg_wr_en    (arg_wr_en),
    .arg_wr_idx   (arg_wr_idx),
    .arg_wr_data  (arg_wr_data),
    .issue        (issue),
    .issue_opcode (issue_opcode),
    .issue_flags  (issue_flags),
    .issue_len    (issue_len),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .busy         (busy),
    .done         (done),
    .err_len      (err_len),
    .err_wr       (err_wr)
`ifdef CMD_STREAM_TX_STATS_EN
    ,
    .stat_pkts    (stat_pkts),
    .stat_words   (stat_words),
    .stat_stall   (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Observations from the last run_stream call.
  logic [31:0] got_q[$];
  int          done_cnt;
  int          busy_cyc;
  int          stall_cyc;
  bit          stable_ok;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_arg(input int idx, input logic [31:0] data);
    arg_wr_en   = 1'b1;
    arg_wr_idx  = IW'(idx);
    arg_wr_data = data;
    step();
    arg_wr_en   = 1'b0;
  endtask

  task automatic do_issue(input logic [7:0] op, input logic [7:0] fl, input logic [15:0] len);
    issue        = 1'b1;
    issue_opcode = op;
    issue_flags  = fl;
    issue_len    = len;
    step();
    issue        = 1'b0;
  endtask

  // Drives cmd_ready (mode 0: always 1, mode 1: pattern 1,0,0 repeating) and
  // records transferred words until done is seen or the cycle budget ends.
  // Returns positioned at the sample point where done is high.
  task automatic run_stream(input int mode, input int max_cycles);
    bit          holding = 1'b0;
    logic [31:0] held    = '0;
    got_q.delete();
    done_cnt  = 0;
    busy_cyc  = 0;
    stall_cyc = 0;
    stable_ok = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      cmd_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      if (done) begin
        done_cnt++;
        break;
      end
      if (busy) busy_cyc++;
      if (cmd_valid) begin
        if (holding && (cmd_data !== held)) stable_ok = 1'b0;
        if (cmd_ready) begin
          got_q.push_back(cmd_data);
          holding = 1'b0;
        end else begin
          stall_cyc++;
          holding = 1'b1;
          held    = cmd_data;
        end
      end
      step();
    end
    cmd_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (cmd_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", cmd_valid); else passed++;
    total++; if (cmd_data !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", cmd_data); else passed++;
    total++; if ({busy, done, err_len, err_wr} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, err_len, err_wr}); else passed++;
    rst = 1'b0;
    step();
    total++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_set_viewport();
    logic [31:0] exp_w [5] = '{32'h11000004, 32'h0, 32'h0, 32'h4, 32'h3};
    write_arg(0, 32'd0);
    write_arg(1, 32'd0);
    write_arg(2, 32'd4);
    write_arg(3, 32'd3);
    do_issue(8'h11, 8'h00, 16'd4);
    total++; if (cmd_valid !== 1'b1 || cmd_data !== 32'h11000004)
      $display("FAIL vp_latency: got valid=%b data=%h expected valid=1 data=11000004", cmd_valid, cmd_data); else passed++;
    run_stream(0, 50);
    total++; if (got_q.size() != 5) $display("FAIL vp_count: got %0d words expected 5", got_q.size()); else passed++;
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_w[i]) $display("FAIL vp_word%0d: got %h expected %h", i, got_q[i], exp_w[i]); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL vp_done: got %0d expected 1", done_cnt); else passed++;
    total++; if (busy_cyc != 5) $display("FAIL vp_busy_cycles: got %0d expected 5", busy_cyc); else passed++;
    total++; if (cmd_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL vp_idle_at_done: got valid=%b busy=%b expected 0 0", cmd_valid, busy); else passed++;
    step();
    total++; if (done !== 1'b0) $display("FAIL vp_done_pulse: got %b expected 0", done); else passed++;
  endtask

  task automatic test_clear();
    do_issue(OP_CLEAR, 8'h00, 16'd0);
    run_stream(0, 20);
    total++; if (got_q.size() != 1) $display("FAIL clr_count: got %0d words expected 1", got_q.size()); else passed++;
    if (got_q.size() > 0) begin
      total++; if (got_q[0] !== 32'h01000000) $display("FAIL clr_word: got %h expected 01000000", got_q[0]); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL clr_done: got %0d expected 1", done_cnt); else passed++;
  endtask

  // Issue accepted in the same cycle done is high; also a write that lands
  // in the same cycle as the accepted issue must be the value sent.
  task automatic test_back_to_back();
    do_issue(OP_CLEAR, 8'h00, 16'd0);
    run_stream(0, 20);
    total++; if (done !== 1'b1) $display("FAIL b2b_done_seen: got %b expected 1", done); else passed++;
    arg_wr_en   = 1'b1;
    arg_wr_idx  = 3'd0;
    arg_wr_data = 32'h00ABCDEF;
    do_issue(OP_SET_COLOR, 8'h7E, 16'd1);
    arg_wr_en   = 1'b0;
    total++; if (cmd_valid !== 1'b1 || cmd_data !== 32'h107E0001)
      $display("FAIL b2b_accept: got valid=%b data=%h expected valid=1 data=107e0001", cmd_valid, cmd_data); else passed++;
    run_stream(0, 20);
    total++; if (got_q.size() != 2 || got_q[1] !== 32'h00ABCDEF)
      $display("FAIL b2b_same_cycle_write: got %0d words last=%h expected 2 words last=00abcdef",
               got_q.size(), (got_q.size() > 0) ? got_q[got_q.size()-1] : 32'hx); else passed++;
  endtask

  task automatic test_draw_triangle();
    logic [31:0] exp_w [7] = '{32'h02000006, 32'd10, 32'd10, 32'd50, 32'd10, 32'd30, 32'd40};
    logic [31:0] vals  [6] = '{32'd10, 32'd10, 32'd50, 32'd10, 32'd30, 32'd40};
`ifdef CMD_STREAM_TX_STATS_EN
    logic [31:0] stall0, words0, pkts0;
`endif
    for (int i = 0; i < 6; i++) write_arg(i, vals[i]);
`ifdef CMD_STREAM_TX_STATS_EN
    stall0 = stat_stall;
    words0 = stat_words;
    pkts0  = stat_pkts;
`endif
    do_issue(OP_DRAW_TRIANGLE, 8'h00, 16'd6);
    run_stream(1, 100);
    total++; if (got_q.size() != 7) $display("FAIL tri_count: got %0d words expected 7", got_q.size()); else passed++;
    for (int i = 0; i < 7 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_w[i]) $display("FAIL tri_word%0d: got %h expected %h", i, got_q[i], exp_w[i]); else passed++;
    end
    total++; if (stable_ok !== 1'b1) $display("FAIL tri_stable: got %b expected 1", stable_ok); else passed++;
    total++; if (stall_cyc != 12) $display("FAIL tri_stalls: got %0d expected 12", stall_cyc); else passed++;
    total++; if (done_cnt != 1) $display("FAIL tri_done: got %0d expected 1", done_cnt); else passed++;
`ifdef CMD_STREAM_TX_STATS_EN
    total++; if (stat_stall - stall0 !== 32'd12) $display("FAIL tri_stat_stall: got %0d expected 12", stat_stall - stall0); else passed++;
    total++; if (stat_words - words0 !== 32'd7) $display("FAIL tri_stat_words: got %0d expected 7", stat_words - words0); else passed++;
    step();
    total++; if (stat_pkts - pkts0 !== 32'd1) $display("FAIL tri_stat_pkts: got %0d expected 1", stat_pkts - pkts0); else passed++;
`endif
  endtask

  task automatic test_len_error();
    do_issue(OP_SET_COLOR, 8'h00, 16'd9);
    total++; if (err_len !== 1'b1) $display("FAIL len_err_pulse: got %b expected 1", err_len); else passed++;
    total++; if (cmd_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL len_err_idle: got valid=%b busy=%b expected 0 0", cmd_valid, busy); else passed++;
    step();
    total++; if (err_len !== 1'b0 || cmd_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL len_err_after: got err_len=%b valid=%b busy=%b expected 0 0 0", err_len, cmd_valid, busy); else passed++;
    // Largest legal length must be accepted.
    do_issue(OP_SET_COLOR, 8'h00, 16'd8);
    total++; if (err_len !== 1'b0 || cmd_valid !== 1'b1)
      $display("FAIL len_max_ok: got err_len=%b valid=%b expected 0 1", err_len, cmd_valid); else passed++;
    run_stream(0, 40);
    total++; if (got_q.size() != 9) $display("FAIL len_max_count: got %0d words expected 9", got_q.size()); else passed++;
  endtask

  task automatic test_busy_misuse();
    write_arg(0, 32'h00FF0000);
    cmd_ready = 1'b0;
    do_issue(OP_SET_COLOR, 8'h00, 16'd1);
    // Second issue and an arg write while the header is stalled.
    arg_wr_en   = 1'b1;
    arg_wr_idx  = 3'd0;
    arg_wr_data = 32'hDEADBEEF;
    do_issue(OP_DRAW_TRIANGLE, 8'h00, 16'd3);
    arg_wr_en   = 1'b0;
    total++; if (err_wr !== 1'b1) $display("FAIL misuse_err_wr: got %b expected 1", err_wr); else passed++;
    total++; if (cmd_data !== 32'h10000001) $display("FAIL misuse_hdr_hold: got %h expected 10000001", cmd_data); else passed++;
    run_stream(0, 20);
    total++; if (got_q.size() != 2) $display("FAIL misuse_count: got %0d words expected 2", got_q.size()); else passed++;
    if (got_q.size() == 2) begin
      total++; if (got_q[1] !== 32'h00FF0000) $display("FAIL misuse_payload: got %h expected 00ff0000", got_q[1]); else passed++;
    end
    total++; if (err_wr !== 1'b1) $display("FAIL misuse_sticky: got %b expected 1", err_wr); else passed++;
    step();
    do_issue(OP_CLEAR, 8'h00, 16'd0);
    total++; if (err_wr !== 1'b0) $display("FAIL misuse_clear: got %b expected 0", err_wr); else passed++;
    run_stream(0, 20);
  endtask

  task automatic test_reset_mid_packet();
    for (int i = 0; i < 4; i++) write_arg(i, 32'hA0 + 32'(i));
    do_issue(OP_SET_VIEWPORT, 8'h00, 16'd4);
    step();  // header moves, buf[0] presented
    step();  // buf[0] moves, buf[1] presented (payload word 2)
    total++; if (cmd_data !== 32'hA1) $display("FAIL rstmid_pre: got %h expected 000000a1", cmd_data); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (cmd_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rstmid_async: got valid=%b busy=%b expected 0 0", cmd_valid, busy); else passed++;
    step();
    step();
    total++; if (done !== 1'b0) $display("FAIL rstmid_no_done: got %b expected 0", done); else passed++;
    rst = 1'b0;
    step();
    total++; if (done !== 1'b0 || cmd_valid !== 1'b0)
      $display("FAIL rstmid_release: got done=%b valid=%b expected 0 0", done, cmd_valid); else passed++;
    do_issue(OP_SET_VIEWPORT, 8'h5A, 16'd2);
    run_stream(0, 20);
    total++; if (got_q.size() != 3) $display("FAIL rstmid_count: got %0d words expected 3", got_q.size()); else passed++;
    if (got_q.size() == 3) begin
      total++; if (got_q[0] !== 32'h115A0002) $display("FAIL rstmid_hdr: got %h expected 115a0002", got_q[0]); else passed++;
      total++; if (got_q[1] !== 32'hA0 || got_q[2] !== 32'hA1)
        $display("FAIL rstmid_payload: got %h %h expected 000000a0 000000a1", got_q[1], got_q[2]); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL rstmid_done: got %0d expected 1", done_cnt); else passed++;
  endtask

  initial begin
    rst          = 1'b1;
    arg_wr_en    = 1'b0;
    arg_wr_idx   = '0;
    arg_wr_data  = '0;
    issue        = 1'b0;
    issue_opcode = '0;
    issue_flags  = '0;
    issue_len    = '0;
    cmd_ready    = 1'b1;

    test_reset();
    test_set_viewport();
    step();
    test_clear();
    step();
    test_back_to_back();
    step();
    test_draw_triangle();
    step();
    test_len_error();
    step();
    test_busy_misuse();
    step();
    test_reset_mid_packet();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/cmd_stream_tx.md
Name: cmd_stream_tx

Overview:
- Initiator side of the GPU command-word stream (`cmd_valid`/`cmd_data`/`cmd_ready`) that `command_processor` consumes.
- The host/CPU-side logic stages up to MAX_PAYLOAD argument words in a local buffer, then pulses `issue` with opcode/flags/length.
- The block serialises one header word `{opcode[7:0], flags[7:0], len[15:0]}` followed by `len` payload words, honouring backpressure.
- Sits between the AXI-lite register shim and `command_processor`.

Parameters:
- MAX_PAYLOAD, 8, payload buffer depth in 32-bit words; legal `len` is 0..MAX_PAYLOAD.
- IDX_W, $clog2(MAX_PAYLOAD), payload index width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- arg_wr_en  in  1  write strobe into payload buffer
- arg_wr_idx  in  IDX_W  payload word index
- arg_wr_data  in  32  payload word
- issue  in  1  single-cycle request to send a packet
- issue_opcode  in  8  header opcode
- issue_flags  in  8  header flags
- issue_len  in  16  payload word count
- cmd_valid  out  1  stream word valid
- cmd_data  out  32  stream word
- cmd_ready  in  1  consumer accepts word
- busy  out  1  packet in flight (state != ST_IDLE)
- done  out  1  one-cycle pulse after final word transfers
- err_len  out  1  one-cycle pulse: issue rejected, `issue_len > MAX_PAYLOAD`
- err_wr  out  1  sticky: arg write attempted while busy; cleared by next accepted issue

Behaviour:
- Reset:
  - `cmd_valid`=0, `cmd_data`=0, `busy`=0, `done`=0, `err_len`=0, `err_wr`=0, state=ST_IDLE.
  - Buffer contents are not reset.
  - Reset asserted mid-packet drops `cmd_valid` asynchronously; the packet is abandoned with no `done`.
- Transfer rule: a word moves on a rising edge with `cmd_valid && cmd_ready`. While `cmd_valid && !cmd_ready`, `cmd_data` holds stable.
- All outputs are registered.
- States:
  - ST_IDLE, `issue` with `issue_len <= MAX_PAYLOAD`:
    - Latch len, load `cmd_data` = header, `cmd_valid`=1.
    - Clear `err_wr`; go ST_HDR.
    - Latency: `cmd_valid` high the cycle after `issue`.
  - ST_IDLE, `issue` with `issue_len > MAX_PAYLOAD`:
    - Pulse `err_len` next cycle; stay ST_IDLE; no `cmd_valid`.
  - ST_HDR, on transfer:
    - len==0: drop `cmd_valid`, pulse `done`, go ST_IDLE.
    - len>0: load `cmd_data` = buf[0] the same edge (no bubble), word counter=1, go ST_PAY.
  - ST_PAY, on transfer:
    - If counter==len: drop `cmd_valid`, pulse `done`, go ST_IDLE.
    - Else load buf[counter], counter++.
- `issue` outside ST_IDLE is ignored silently.
- `issue` in the same cycle `done` is high is accepted, because state is already ST_IDLE.
- With `cmd_ready` held high, throughput is one word per clock.
- `arg_wr_en` while busy: write discarded, `err_wr` set.
- `arg_wr_en` in ST_IDLE in the same cycle as an accepted `issue`: the write lands before the buffer is read. buf[0] is not read until after the header transfer, so the new value is sent.
- `arg_wr_idx >= MAX_PAYLOAD` (non-power-of-2 depth): write discarded.
- The counter is 16-bit internally; `len` is checked before use, so the counter cannot wrap.

Optional Feature:
- Macro `CMD_STREAM_TX_STATS_EN`. When defined, adds three outputs, each cleared by `rst`, saturating at all-ones, and not otherwise cleared:
  - `stat_pkts` [31:0]: count of `done` pulses.
  - `stat_words` [31:0]: count of transfers.
  - `stat_stall` [31:0]: cycles with `cmd_valid && !cmd_ready`.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package `gpu_cmd_pkg`:
  - Opcode constants OP_CLEAR=8'h01, OP_DRAW_TRIANGLE=8'h02, OP_SET_COLOR=8'h10, OP_SET_VIEWPORT=8'h11.
  - Packed header struct `{opcode, flags, len}` and field widths.
  - State enum for this block.
- One sub-module: `cmd_payload_buf`. It is a MAX_PAYLOAD×32 register file with a write port (enable gated by `!busy`) and a combinational read port addressed by the word counter.

Test Plan:
- SET_VIEWPORT:
  - Stimulus: write buf = 0,0,4,3; issue 0x11/0x00/len 4; `cmd_ready` always high.
  - Response: stream 0x11000004, 0, 0, 4, 3 on 5 consecutive edges; `done` one cycle later; `busy` high exactly 5 cycles.
- CLEAR:
  - Stimulus: issue 0x01, len 0.
  - Response: single word 0x01000000, then `done`.
- DRAW_TRIANGLE:
  - Stimulus: buf = 10,10,50,10,30,40; `cmd_ready` toggles 1,0,0,1,...
  - Response: 7 words in order with `cmd_data` stable across stalls; `stat_stall` equals stall cycles when `CMD_STREAM_TX_STATS_EN` is defined.
- Length error:
  - Stimulus: issue len 9 (MAX_PAYLOAD=8).
  - Response: `err_len` pulses once, `cmd_valid` stays 0, `busy` stays 0.
- Busy-time misuse:
  - Stimulus: a second issue and an arg write during a SET_COLOR packet (0x10000001, 0xFF0000).
  - Response: second issue ignored; `err_wr`=1; payload sent is 0xFF0000; `err_wr` clears on next issue.
- Reset mid-packet:
  - Stimulus: assert `rst` during ST_PAY word 2.
  - Response: `cmd_valid`=0 immediately, no `done`; a fresh issue after release streams correctly from the header.
